// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared types for the NoC input port: flit type encodings,
//               input-port FSM state encodings and flit-width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Two-bit flit type carried in the top bits of every flit
    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Input-port arbitration/forwarding states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } port_state_e;

    localparam int c_TYPE_W = 2;

    // Full flit width for a given payload width
    function automatic int flit_width(input int data_w);
        return data_w + c_TYPE_W;
    endfunction

    // A packet ends on a TAIL flit or a SINGLE (head+tail) flit
    function automatic logic is_tail(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered full/empty flags and an
//               occupancy count. Head entry is visible on dout while not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_full;
    logic               r_empty;

    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_nxt;

    // Requests are qualified by the registered flags so overflow/underflow cannot occur
    assign w_push = push && !r_full;
    assign w_pop  = pop  && !r_empty;

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

    // Next occupancy; simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_port
// Description : NoC router input port. Buffers incoming flits in a FIFO,
//               requests the round-robin arbiter while a packet is pending and
//               forwards one flit per granted cycle through a registered output.
//               Optional macro NOC_INPUT_PORT_STATS_EN adds a 16-bit wrapping
//               forwarded-flit counter on output flit_count.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_input_port
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int FLIT_W = flit_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              req,
    input  logic              grant,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit
`ifdef NOC_INPUT_PORT_STATS_EN
    ,
    output logic [15:0]       flit_count
`endif
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    port_state_e        r_state;
    logic               r_req;
    logic               r_out_valid;
    logic [FLIT_W-1:0]  r_out_flit;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FLIT_W-1:0]  w_fifo_head;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_push;
    logic               w_pop;
    logic               w_head_is_tail;
    logic               w_empty_after_pop;

    // Backpressure comes straight from the registered full flag, so a pop in
    // the same cycle never frees a slot early
    assign in_ready = !w_fifo_full;
    assign w_push   = in_valid && !w_fifo_full;

    // Pops only happen while holding (or requesting) the arbiter; grants in IDLE are ignored
    assign w_pop = grant && !w_fifo_empty && ((r_state == ST_REQ) || (r_state == ST_SEND));

    assign w_head_is_tail    = is_tail(flit_type_e'(w_fifo_head[FLIT_W-1 -: c_TYPE_W]));
    // Occupancy after this cycle's pop, accounting for a concurrent push
    assign w_empty_after_pop = (w_fifo_count == c_CNT_W'(1)) && !w_push;

    sync_fifo #(
        .DATA_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_flit),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Arbitration FSM with registered request: hold req across a packet, drop it only when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                    end
                end
                ST_REQ, ST_SEND: begin
                    if (w_pop) begin
                        if (w_head_is_tail) begin
                            if (w_empty_after_pop) begin
                                r_state <= ST_IDLE;
                                r_req   <= 1'b0;
                            end else begin
                                r_state <= ST_REQ;
                                r_req   <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_SEND;
                            r_req   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Registered output stage: popped flit appears the cycle after the pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_out_flit <= w_fifo_head;
            end
        end
    end

    assign req       = r_req;
    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;

`ifdef NOC_INPUT_PORT_STATS_EN
    logic [15:0] r_flit_count;

    // Count flits as they are presented downstream; wraps at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flit_count <= '0;
        end else if (r_out_valid) begin
            r_flit_count <= r_flit_count + 16'd1;
        end
    end

    assign flit_count = r_flit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_input_port
// Description : Self-checking bench for noc_input_port: directed vector table,
//               hand-written multi-cycle sequences and a randomized run against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_input_port;
    import noc_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int FW     = DATA_W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [FW-1:0] in_flit;
    logic          in_ready;
    logic          req;
    logic          grant;
    logic          out_valid;
    logic [FW-1:0] out_flit;
`ifdef NOC_INPUT_PORT_STATS_EN
    logic [15:0]   flit_count;
`endif

    noc_input_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_flit  (out_flit)
`ifdef NOC_INPUT_PORT_STATS_EN
        ,
        .flit_count(flit_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic iv, input logic [FW-1:0] fl, input logic gr);
        in_valid = iv;
        in_flit  = fl;
        grant    = gr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        grant    = 1'b0;
        in_flit  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        string         tag;
        logic          iv;
        logic [FW-1:0] fl;
        logic          gr;
        logic          e_rdy;
        logic          e_req;
        logic          e_ov;
        logic [FW-1:0] e_fl;
    } vec_t;

    vec_t vt[$];

    function automatic void addv(input string tag, input logic iv, input logic [1:0] ty,
                                 input logic [31:0] pl, input logic gr, input logic rdy,
                                 input logic rq, input logic ov, input logic [1:0] ety,
                                 input logic [31:0] epl);
        vec_t v;
        v.tag   = tag;
        v.iv    = iv;
        v.fl    = {ty, pl};
        v.gr    = gr;
        v.e_rdy = rdy;
        v.e_req = rq;
        v.e_ov  = ov;
        v.e_fl  = {ety, epl};
        vt.push_back(v);
    endfunction

    // Reference model state: buffered flits, request line, and whether the
    // port currently owns the output (granted, mid-packet)
    logic [FW-1:0] mq[$];
    bit            m_req;
    bit            m_stream;

    initial begin
        int            sz0;
        bit            e_pop;
        bit            rs;
        bit            iv;
        bit            gr;
        logic [FW-1:0] fl;
        logic [FW-1:0] f;

        reset    = 1'b1;
        in_valid = 1'b0;
        grant    = 1'b0;
        in_flit  = '0;

        // Reset state
        do_reset();
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_req", req, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_flit", out_flit, '0);

        // Single flit, grant held
        addv("single_c1", 1, 2'b11, 32'hAA, 1, 1, 0, 0, 2'b00, 0);
        addv("single_c2", 0, 2'b00, 0,      1, 1, 1, 0, 2'b00, 0);
        addv("single_c3", 0, 2'b00, 0,      1, 1, 0, 1, 2'b11, 32'hAA);
        addv("single_c4", 0, 2'b00, 0,      1, 1, 0, 0, 2'b00, 0);
        // HEAD, BODY, TAIL, grant held
        addv("pkt_c1", 1, 2'b01, 32'h11, 1, 1, 0, 0, 2'b00, 0);
        addv("pkt_c2", 1, 2'b00, 32'h22, 1, 1, 1, 0, 2'b00, 0);
        addv("pkt_c3", 1, 2'b10, 32'h33, 1, 1, 1, 1, 2'b01, 32'h11);
        addv("pkt_c4", 0, 2'b00, 0,      1, 1, 1, 1, 2'b00, 32'h22);
        addv("pkt_c5", 0, 2'b00, 0,      1, 1, 0, 1, 2'b10, 32'h33);
        addv("pkt_c6", 0, 2'b00, 0,      1, 1, 0, 0, 2'b00, 0);
        // Fill to full without grant; fifth flit refused, then drain
        addv("full_c1", 1, 2'b01, 32'hA1, 0, 1, 0, 0, 2'b00, 0);
        addv("full_c2", 1, 2'b00, 32'hA2, 0, 1, 1, 0, 2'b00, 0);
        addv("full_c3", 1, 2'b00, 32'hA3, 0, 1, 1, 0, 2'b00, 0);
        addv("full_c4", 1, 2'b10, 32'hA4, 0, 0, 1, 0, 2'b00, 0);
        addv("full_c5", 1, 2'b11, 32'hA5, 0, 0, 1, 0, 2'b00, 0);
        addv("full_c6", 0, 2'b00, 0,      1, 1, 1, 1, 2'b01, 32'hA1);
        addv("full_c7", 0, 2'b00, 0,      1, 1, 1, 1, 2'b00, 32'hA2);
        addv("full_c8", 0, 2'b00, 0,      1, 1, 1, 1, 2'b00, 32'hA3);
        addv("full_c9", 0, 2'b00, 0,      1, 1, 0, 1, 2'b10, 32'hA4);
        addv("full_c10", 0, 2'b00, 0,     1, 1, 0, 0, 2'b00, 0);
        addv("full_c11", 0, 2'b00, 0,     1, 1, 0, 0, 2'b00, 0);

        foreach (vt[i]) begin
            step(vt[i].iv, vt[i].fl, vt[i].gr);
            chk($sformatf("%s_in_ready", vt[i].tag), in_ready, vt[i].e_rdy);
            chk($sformatf("%s_req", vt[i].tag), req, vt[i].e_req);
            chk($sformatf("%s_out_valid", vt[i].tag), out_valid, vt[i].e_ov);
            if (vt[i].e_ov) begin
                chk($sformatf("%s_out_flit", vt[i].tag), out_flit, vt[i].e_fl);
            end
        end

        // FIFO runs dry mid-packet: bubbles with req held, TAIL follows later
        step(1, {2'b01, 32'hB1}, 1);
        chk("dry_c1_req", req, 1'b0);
        step(0, '0, 1);
        chk("dry_c2_req", req, 1'b1);
        step(0, '0, 1);
        chk("dry_c3_out_valid", out_valid, 1'b1);
        chk("dry_c3_out_flit", out_flit, {2'b01, 32'hB1});
        step(0, '0, 1);
        chk("dry_c4_out_valid", out_valid, 1'b0);
        chk("dry_c4_req", req, 1'b1);
        step(0, '0, 1);
        chk("dry_c5_out_valid", out_valid, 1'b0);
        chk("dry_c5_req", req, 1'b1);
        step(1, {2'b10, 32'hB2}, 1);
        chk("dry_c6_out_valid", out_valid, 1'b0);
        chk("dry_c6_req", req, 1'b1);
        step(0, '0, 1);
        chk("dry_c7_out_valid", out_valid, 1'b1);
        chk("dry_c7_out_flit", out_flit, {2'b10, 32'hB2});
        chk("dry_c7_req", req, 1'b0);
        step(0, '0, 1);
        chk("dry_c8_out_valid", out_valid, 1'b0);

        // Reset in SEND with three flits still buffered
        step(1, {2'b01, 32'hC1}, 0);
        step(1, {2'b00, 32'hC2}, 0);
        step(1, {2'b00, 32'hC3}, 0);
        step(1, {2'b00, 32'hC4}, 0);
        step(0, '0, 1);
        chk("mid_rst_pre_out_flit", out_flit, {2'b01, 32'hC1});
        reset = 1'b1;
        step(1, {2'b10, 32'hC5}, 1);
        reset = 1'b0;
        chk("mid_rst_req", req, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_flit", out_flit, '0);
        for (int k = 0; k < 5; k++) begin
            step(0, '0, 1);
            chk($sformatf("mid_rst_after%0d_out_valid", k), out_valid, 1'b0);
            chk($sformatf("mid_rst_after%0d_req", k), req, 1'b0);
        end

        // Randomized run against the reference model
        do_reset();
        mq.delete();
        m_req    = 1'b0;
        m_stream = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            iv = ($urandom_range(0, 99) < 60);
            gr = ($urandom_range(0, 99) < 70);
            rs = ($urandom_range(0, 299) == 0);
            fl = {2'($urandom_range(0, 3)), 32'($urandom)};
            e_pop = 1'b0;
            f     = '0;
            if (rs) begin
                mq.delete();
                m_req    = 1'b0;
                m_stream = 1'b0;
            end else begin
                sz0   = mq.size();
                e_pop = m_req && gr && (sz0 > 0);
                if (e_pop) begin
                    f = mq.pop_front();
                end
                if (iv && (sz0 < DEPTH)) begin
                    mq.push_back(fl);
                end
                if (!m_req) begin
                    m_req    = (sz0 > 0);
                    m_stream = 1'b0;
                end else if (e_pop) begin
                    // type[1] set marks TAIL or SINGLE: packet ends here
                    if (f[FW-1]) begin
                        m_stream = 1'b0;
                        m_req    = (mq.size() != 0);
                    end else begin
                        m_stream = 1'b1;
                    end
                end
            end
            reset = rs;
            step(iv, fl, gr);
            reset = 1'b0;
            chk("rand_req", req, m_req);
            chk("rand_out_valid", out_valid, e_pop);
            chk("rand_in_ready", in_ready, (mq.size() < DEPTH));
            if (e_pop) begin
                chk("rand_out_flit", out_flit, f);
            end
            if (rs) begin
                chk("rand_rst_out_flit", out_flit, '0);
            end
        end

`ifdef NOC_INPUT_PORT_STATS_EN
        // Stream 65537 flits in one packet so the counter wraps to 1
        begin
            int         idx;
            int         budget;
            logic       acc;
            logic [1:0] ty;
            do_reset();
            chk("stats_reset", flit_count, 16'h0000);
            idx    = 0;
            budget = 0;
            while (idx < 65537 && budget < 70000) begin
                ty  = (idx == 0) ? 2'b01 : ((idx == 65536) ? 2'b10 : 2'b00);
                acc = in_ready;
                step(1, {ty, 32'(idx)}, 1);
                if (acc) idx++;
                budget++;
            end
            checks++;
            if (idx != 65537) begin
                errors++;
                $display("FAIL stats_stream: pushed %0d required 65537", idx);
            end
            for (int k = 0; k < 8; k++) step(0, '0, 1);
            chk("stats_wrap", flit_count, 16'h0001);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_input_port.md
NOC_INPUT_PORT -- requirements
Module: noc_input_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload bits per flit.
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream flit present.
REQ-006 SHALL have port in_flit  input  DATA_W+2  {type[1:0], payload}.
REQ-007 SHALL have port in_ready  output  1  high when the FIFO is not full.
REQ-008 SHALL have port req  output  1  request to the round-robin arbiter.
REQ-009 SHALL have port grant  input  1  arbiter grant for this port.
REQ-010 SHALL have port out_valid  output  1  forwarded flit valid.
REQ-011 SHALL have port out_flit  output  DATA_W+2  forwarded flit.

Function
REQ-012 SHALL decode flit type: 2'b00 BODY, 2'b01 HEAD, 2'b10 TAIL, 2'b11 SINGLE (head and tail).
REQ-013 SHALL push in_flit into the FIFO when in_valid && in_ready.
REQ-014 SHALL implement FSM states IDLE, REQ, SEND.
REQ-015 IDLE -> REQ when FIFO non-empty; req SHALL be low in IDLE and high in REQ and SEND.
REQ-016 REQ -> SEND on grant; the head FIFO entry SHALL be popped in that same cycle.
REQ-017 In SEND, SHALL pop one flit each cycle grant && FIFO non-empty; no pop if empty (bubble, req held).
REQ-018 On popping a TAIL or SINGLE flit, SHALL go to IDLE if FIFO then empty, else REQ, dropping req for at least one cycle in the IDLE case only.
REQ-019 Popped flit SHALL appear on out_flit with out_valid high exactly one cycle after the pop (registered output); out_valid low otherwise.
REQ-020 Grant while in IDLE SHALL be ignored (no pop).
REQ-021 Simultaneous push and pop on a full FIFO SHALL NOT occur: in_ready is computed from the registered full flag, so push is blocked when full even if popping.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the count unchanged.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-024 Flits SHALL leave in arrival order; none dropped or duplicated.

Reset
REQ-025 On reset: FSM IDLE, FIFO empty, req 0, out_valid 0, out_flit 0, in_ready 1 the cycle after.
REQ-026 Reset mid-packet SHALL discard all buffered flits and take priority over push/pop that cycle.

Configuration
REQ-027 With NOC_INPUT_PORT_STATS_EN defined, SHALL add output flit_count (16 bits) counting forwarded flits, wrapping 16'hFFFF -> 0, cleared by reset.
REQ-028 Without NOC_INPUT_PORT_STATS_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Flit type encodings, FSM state encodings and flit-width helper SHALL live in shared package noc_pkg.
REQ-030 Storage SHALL be a sub-module sync_fifo (parameters DATA_W+2, DEPTH; push/pop/full/empty).

Verification
REQ-031 Reset then SINGLE flit 0x0000_00AA, grant held high -> req high cycle 2, out_flit {11,0xAA} out_valid one cycle after grant, req low next.
REQ-032 HEAD,BODY,TAIL pushed, grant held -> three consecutive out_valid cycles in order, req never drops mid-packet.
REQ-033 Push 5 flits with DEPTH=4, no grant -> in_ready low after 4th, 5th not accepted, occupancy 4.
REQ-034 HEAD sent, FIFO empty before TAIL arrives -> state stays SEND, req high, out_valid low, TAIL forwarded one cycle after arrival pop.
REQ-035 Reset asserted with 3 flits buffered in SEND -> next cycle req 0, out_valid 0, in_ready 1, no stale flit ever emitted.
REQ-036 With NOC_INPUT_PORT_STATS_EN, preset counter near 16'hFFFF, forward 2 flits -> flit_count wraps to 16'h0001.
